rnn_layer_sequencer: RTL and testbench



---
 rtl/rnn_seq_pkg.sv | 18 +
 rtl/rnn_layer_sequencer_watchdog.sv | 19 +
 rtl/rnn_layer_sequencer.sv | 78 +++++++
 tb/tb_rnn_layer_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_seq_pkg.sv
// rnn_seq_pkg: layer indices, dependency masks, FSM encoding and error bit positions for the RNNoise layer sequencer.
package rnn_seq_pkg;
  localparam int NUM_LAYERS = 6;
  localparam int L_DENSE1 = 0;
  localparam int L_GRU1 = 1;
  localparam int L_DENSE2 = 2;
  localparam int L_GRU2 = 3;
  localparam int L_GRU3 = 4;
  localparam int L_DENSE3 = 5;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_PROTO = 1;
  typedef logic [NUM_LAYERS-1:0] layer_mask_t;
  // Bit j of DEP[k] set means layer k waits for layer j to finish.
  localparam layer_mask_t DEP [NUM_LAYERS] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b000010, 6'b001000, 6'b010000
  };
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/rnn_layer_sequencer_watchdog.sv
// seq_watchdog: counts event-free RUN cycles and flags a timeout on the TIMEOUT-th one.
module seq_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int TIMEOUT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic timeout
);
  logic [TIMEOUT_W-1:0] cnt;
  // cnt holds idle cycles already elapsed, so the current idle cycle is number cnt+1.
  assign timeout = run && !clear && cnt == TIMEOUT_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear || !run) cnt <= '0;
    else cnt <= cnt + TIMEOUT_W'(1);
endmodule

// File: rtl/rnn_layer_sequencer.sv
// rnn_layer_sequencer: per-frame dependency scheduler for the six RNNoise layer engines with watchdog abort.
module rnn_layer_sequencer import rnn_seq_pkg::*; #(
  parameter int TIMEOUT = 4096,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic             clear_state,
  output logic             gru_clr,
  output logic [5:0]       layer_start,
  input  logic [5:0]       layer_done,
  output logic             abort,
  output logic             vad_valid,
  output logic             gains_valid,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] frame_count
);
  state_t state;
  layer_mask_t started, done, can_start, valid_done, done_nxt;
  logic run, accept, timeout, event_seen, finish;
  assign run = state == RUN;
  assign frame_ready = state == IDLE;
  assign busy = run;
  assign accept = frame_valid && frame_ready;
  always_comb begin
    can_start = '0;
    for (int k = 0; k < NUM_LAYERS; k++)
      can_start[k] = run && !started[k] && (DEP[k] & ~done) == '0;
  end
  assign layer_start = can_start;
  // A start only fires where started is clear, so started also excludes the start cycle.
  assign valid_done = run ? layer_done & started & ~done : '0;
  assign done_nxt = done | valid_done;
  assign finish = run && !timeout && &done_nxt;
  assign event_seen = |can_start || |valid_done;
  assign abort = timeout;
  seq_watchdog #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) u_wd (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(event_seen), .timeout(timeout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      started <= '0;
      done <= '0;
      gru_clr <= 1'b0;
      vad_valid <= 1'b0;
      gains_valid <= 1'b0;
      frame_done <= 1'b0;
      err <= '0;
      frame_count <= '0;
    end else begin
      vad_valid <= !timeout && valid_done[L_DENSE2];
      gains_valid <= !timeout && valid_done[L_DENSE3];
      frame_done <= finish;
      frame_count <= frame_count + CNT_W'(finish);
      err[ERR_PROTO] <= (err[ERR_PROTO] && !accept) || |(layer_done & ~valid_done);
      err[ERR_TIMEOUT] <= (err[ERR_TIMEOUT] && !accept) || timeout;
      if (accept) begin
        state <= RUN;
        started <= '0;
        done <= '0;
        gru_clr <= clear_state;
      end else if (timeout || finish) begin
        state <= IDLE;
        started <= '0;
        done <= '0;
        gru_clr <= 1'b0;
      end else begin
        started <= started | can_start;
        done <= done_nxt;
      end
    end
endmodule

// File: tb/tb_rnn_layer_sequencer.sv
// tb_rnn_layer_sequencer: table-driven, randomized and hand-written frame scenarios checked against a dependency-schedule model.
module tb_rnn_layer_sequencer;
  logic clk = 0, rst_n = 0;
  logic frame_valid = 0, clear_state = 0, fv_t = 0;
  logic [5:0] layer_done = 0, ld_t = 0;
  logic frame_ready, gru_clr, abort, vad_valid, gains_valid, frame_done, busy;
  logic [5:0] layer_start;
  logic [1:0] err;
  logic [15:0] frame_count;
  logic frame_ready_t, gru_clr_t, abort_t, vad_valid_t, gains_valid_t, frame_done_t, busy_t;
  logic [5:0] layer_start_t;
  logic [1:0] err_t;
  logic [15:0] frame_count_t;
  int checks = 0, errors = 0, exp_cnt = 0;
  localparam int PAR [6] = '{-1, 0, 1, 1, 3, 4};

  typedef struct packed {
    logic [5:0][7:0] lat;
    logic [7:0] vad;
    logic [7:0] gains;
    logic [7:0] fd;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  rnn_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .clear_state(clear_state), .gru_clr(gru_clr), .layer_start(layer_start),
    .layer_done(layer_done), .abort(abort), .vad_valid(vad_valid), .gains_valid(gains_valid),
    .frame_done(frame_done), .busy(busy), .err(err), .frame_count(frame_count)
  );

  rnn_layer_sequencer #(.TIMEOUT(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv_t), .frame_ready(frame_ready_t),
    .clear_state(clear_state), .gru_clr(gru_clr_t), .layer_start(layer_start_t),
    .layer_done(ld_t), .abort(abort_t), .vad_valid(vad_valid_t), .gains_valid(gains_valid_t),
    .frame_done(frame_done_t), .busy(busy_t), .err(err_t), .frame_count(frame_count_t)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, a, e);
    end
  endtask

  task automatic cyc(input logic fv, input logic [5:0] ld);
    @(posedge clk); #1;
    frame_valid = fv;
    layer_done = ld;
    @(negedge clk);
  endtask

  task automatic cyc_t(input logic fv, input logic [5:0] ld);
    @(posedge clk); #1;
    fv_t = fv;
    ld_t = ld;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int l0, l1, l2, l3, l4, l5, v, g, f);
    vec_t r;
    r.lat[0] = 8'(l0); r.lat[1] = 8'(l1); r.lat[2] = 8'(l2);
    r.lat[3] = 8'(l3); r.lat[4] = 8'(l4); r.lat[5] = 8'(l5);
    r.vad = 8'(v); r.gains = 8'(g); r.fd = 8'(f);
    return r;
  endfunction

  // Engines answer after lat[k] cycles; each layer starts the cycle after its parent's done.
  task automatic run_frame(input logic [5:0][7:0] lat, input logic clr,
                           output int ov, output int og, output int ofd);
    int st [6], dn [6], fin;
    logic [5:0] es, ld;
    fin = 0;
    for (int k = 0; k < 6; k++) begin
      st[k] = PAR[k] < 0 ? 1 : dn[PAR[k]] + 1;
      dn[k] = st[k] + int'(lat[k]);
      if (dn[k] > fin) fin = dn[k];
    end
    ov = -1; og = -1; ofd = -1;
    for (int c = 0; c <= fin + 1; c++) begin
      es = '0; ld = '0;
      for (int k = 0; k < 6; k++) begin
        es[k] = st[k] == c;
        ld[k] = dn[k] == c;
      end
      @(posedge clk); #1;
      frame_valid = c == 0;
      clear_state = clr;
      layer_done = ld;
      @(negedge clk);
      chk("layer_start", layer_start, es);
      chk("busy", busy, c >= 1 && c <= fin);
      chk("frame_ready", frame_ready, !(c >= 1 && c <= fin));
      chk("gru_clr", gru_clr, clr && c >= 1 && c <= fin);
      chk("vad_valid", vad_valid, c == dn[2] + 1);
      chk("gains_valid", gains_valid, c == dn[5] + 1);
      chk("frame_done", frame_done, c == fin + 1);
      chk("abort", abort, 0);
      if (c >= 1) chk("err", err, 0);
      if (vad_valid && ov < 0) ov = c;
      if (gains_valid && og < 0) og = c;
      if (frame_done && ofd < 0) ofd = c;
    end
    exp_cnt++;
    chk("frame_count", frame_count, exp_cnt);
    @(posedge clk); #1;
    layer_done = '0;
    frame_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int ov, og, ofd;
    logic seen;
    logic [5:0][7:0] lat;
    tbl[0] = mk(1, 1, 1, 1, 1, 1, 7, 11, 11);
    tbl[1] = mk(1, 1, 20, 1, 1, 1, 26, 11, 26);
    tbl[2] = mk(1, 1, 3, 1, 1, 1, 9, 11, 11);
    tbl[3] = mk(2, 3, 1, 4, 2, 5, 10, 22, 22);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frame_ready", frame_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_layer_start", layer_start, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_gru_clr", gru_clr, 0);
    chk("rst_strobes", {abort, vad_valid, gains_valid, frame_done}, 0);
    #2 rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].lat, 0, ov, og, ofd);
      chk("tbl_vad_cycle", ov, tbl[i].vad);
      chk("tbl_gains_cycle", og, tbl[i].gains);
      chk("tbl_done_cycle", ofd, tbl[i].fd);
    end

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 6; k++) lat[k] = 8'($urandom_range(1, 6));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_frame(lat, 1'($urandom_range(0, 1)), ov, og, ofd);
    end

    cyc(0, 6'b100000);
    cyc(0, 0);
    chk("idle_done_err", err, 2);
    cyc(1, 0);
    cyc(0, 6'b001000);
    chk("accept_clears_err", err, 0);
    chk("spur_d1_start", layer_start, 6'b000001);
    cyc(0, 6'b000001);
    chk("early_gru2_err", err, 2);
    cyc(0, 6'b000001);
    chk("spur_g1_start", layer_start, 6'b000010);
    cyc(0, 6'b000010);
    chk("repeat_d1_err", err, 2);
    cyc(0, 0);
    chk("spur_branch_start", layer_start, 6'b001100);
    cyc(0, 6'b001100);
    cyc(0, 0);
    chk("spur_g3_start", layer_start, 6'b010000);
    chk("spur_vad", vad_valid, 1);
    cyc(0, 6'b010000);
    cyc(0, 0);
    chk("spur_d3_start", layer_start, 6'b100000);
    cyc(0, 6'b100000);
    cyc(0, 0);
    chk("spur_frame_done", frame_done, 1);
    chk("spur_err_kept", err, 2);
    exp_cnt++;
    chk("spur_frame_count", frame_count, exp_cnt);
    run_frame(tbl[0].lat, 0, ov, og, ofd);

    cyc_t(1, 0);
    cyc_t(0, 0);
    chk("to_d1_start", layer_start_t, 6'b000001);
    cyc_t(0, 6'b000001);
    cyc_t(0, 0);
    cyc_t(0, 6'b000010);
    cyc_t(0, 0);
    chk("to_branch_start", layer_start_t, 6'b001100);
    cyc_t(0, 6'b001100);
    cyc_t(0, 0);
    chk("to_g3_start", layer_start_t, 6'b010000);
    seen = 0;
    for (int c = 8; c <= 17; c++) begin
      cyc_t(0, 0);
      chk("to_abort", abort_t, c == 15);
      if (c >= 16) begin
        chk("to_idle", busy_t, 0);
        chk("to_ready", frame_ready_t, 1);
      end
      seen = seen | gains_valid_t | frame_done_t | layer_start_t[5];
    end
    chk("to_no_gains", seen, 0);
    chk("to_err", err_t, 1);
    chk("to_frame_count", frame_count_t, 0);

    clear_state = 1;
    cyc(1, 0);
    cyc(0, 0);
    chk("pre_rst_start", layer_start, 1);
    chk("pre_rst_gru_clr", gru_clr, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", frame_ready, 1);
    chk("arst_layer_start", layer_start, 0);
    chk("arst_gru_clr", gru_clr, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_err", err, 0);
    chk("arst_strobes", {abort, vad_valid, gains_valid, frame_done}, 0);
    exp_cnt = 0;
    @(posedge clk); #3;
    rst_n = 1;
    run_frame(tbl[0].lat, 1, ov, og, ofd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
